mem_arbiter: RTL

Shares the single four-word-line main memory port between the instruction-cache FSM and the data-cache FSM. Each cache FSM requests the port, holds it for a whole line transfer (write-back and/or fill), then releases it. The arbiter passes word accesses through combinationally and routes read data back to the issuing requester, using a tag pipeline matched to memory latency. It sits between the two cache_fsm instances and the memory in the memory system top level.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_rd_tag_pipe.sv | 37 +++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the two-cache main-memory arbiter.
package mem_arbiter_pkg;

  // Default timing parameters of the memory system.
  localparam int DEF_MEM_LAT  = 2;
  localparam int DEF_MAX_HOLD = 16;

  // Arbiter states. The grant states are one-hot so each grant output is a
  // straight decode of a single state flop.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT_I = 2'b01,
    ST_GRANT_D = 2'b10
  } arb_state_e;

  // Port owner / requester identity.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // One entry of the read-return tag pipe.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// MEM_LAT-stage shift register of {valid, owner} tags. The output stage lines
// up with the cycle in which memory drives the data for the tagged read.
module mem_arbiter_rd_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [MEM_LAT-1:0] stage_q;

  generate
    if (MEM_LAT == 1) begin : g_single
      // Single-stage pipe: capture the tag of the current cycle.
      always_ff @(posedge clk) begin
        // NOTE: the tag stages are control state, not data storage, so every
        // stage is reset; otherwise an in-flight read could fire a valid after
        // reset.
        if (rst) stage_q <= '0;
        else     stage_q <= tag_i;
      end
    end else begin : g_multi
      // Multi-stage pipe: shift tags one stage per clock toward the output.
      always_ff @(posedge clk) begin
        if (rst) stage_q <= '0;
        else     stage_q <= {stage_q[MEM_LAT-2:0], tag_i};
      end
    end
  endgenerate

  assign tag_o = stage_q[MEM_LAT-1];

endmodule : mem_arbiter_rd_tag_pipe

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between the I-cache and D-cache
// line-transfer FSMs. Word accesses of the owner pass through combinationally;
// read data is routed back using a tag pipe matched to memory latency.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_req,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              i_gnt,
  output logic [DATA_W-1:0] i_data_out,
  output logic              i_rd_valid,
  output logic              i_err,
  // D-cache side
  input  logic              d_req,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data_in,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_data_out,
  output logic              d_rd_valid,
  output logic              d_err,
  // Memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_DataOut,
  // Diagnostics
  output logic              hold_timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  arb_state_e       state_q;
  owner_e           last_owner_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;
  logic             hold_timeout_q;

  // Signals of whichever requester currently owns the port.
  logic              own_req;
  logic              own_rd;
  logic              own_wr;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  owner_e            cur_owner;

  rd_tag_t tag_in;
  rd_tag_t tag_out;

  // Select the owner's request and strobes; nothing is selected when idle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned (no latch).
    own_req   = 1'b0;
    own_rd    = 1'b0;
    own_wr    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    cur_owner = OWN_I;
    case (state_q)
      ST_GRANT_I: begin
        own_req   = i_req;
        own_rd    = i_rd;
        own_wr    = i_wr;
        own_addr  = i_addr;
        own_wdata = i_data_in;
        cur_owner = OWN_I;
      end
      ST_GRANT_D: begin
        own_req   = d_req;
        own_rd    = d_rd;
        own_wr    = d_wr;
        own_addr  = d_addr;
        own_wdata = d_data_in;
        cur_owner = OWN_D;
      end
      default: ;
    endcase
  end

  // Saturating increment of the hold counter.
  assign hold_cnt_d = (hold_cnt_q == CNT_W'(MAX_HOLD)) ? hold_cnt_q
                                                       : hold_cnt_q + 1'b1;

  // Arbitration FSM with its hold counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q        <= ST_IDLE;
      last_owner_q   <= OWN_D;
      hold_cnt_q     <= '0;
      hold_timeout_q <= 1'b0;
    end else begin
      if (own_req && (hold_cnt_q == CNT_W'(MAX_HOLD))) begin
        hold_timeout_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          // On a tie the requester that did not own the port last wins.
          if (i_req && (!d_req || (last_owner_q == OWN_D))) begin
            state_q <= ST_GRANT_I;
          end else if (d_req) begin
            state_q <= ST_GRANT_D;
          end
        end
        ST_GRANT_I: begin
          if (i_req) begin
            hold_cnt_q <= hold_cnt_d;
          end else begin
            last_owner_q <= OWN_I;
            hold_cnt_q   <= '0;
            state_q      <= d_req ? ST_GRANT_D : ST_IDLE;
          end
        end
        ST_GRANT_D: begin
          if (d_req) begin
            hold_cnt_q <= hold_cnt_d;
          end else begin
            last_owner_q <= OWN_D;
            hold_cnt_q   <= '0;
            state_q      <= i_req ? ST_GRANT_I : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Grants are direct decodes of the state register, so they are glitch-free
  // and mutually exclusive.
  assign i_gnt        = (state_q == ST_GRANT_I);
  assign d_gnt        = (state_q == ST_GRANT_D);
  assign hold_timeout = hold_timeout_q;

  // Word passthrough; a simultaneous rd+wr from the owner issues nothing.
  assign mem_rd      = own_req & own_rd & ~own_wr;
  assign mem_wr      = own_req & own_wr & ~own_rd;
  assign mem_addr    = own_addr;
  assign mem_data_in = own_wdata;

  assign i_err = i_gnt & i_req & i_rd & i_wr;
  assign d_err = d_gnt & d_req & d_rd & d_wr;

  // Tag each issued read with its owner so the data returns to the issuer
  // even if ownership has changed by the time memory answers.
  assign tag_in = '{valid: mem_rd, owner: cur_owner};

  mem_arbiter_rd_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign i_rd_valid = tag_out.valid & (tag_out.owner == OWN_I);
  assign d_rd_valid = tag_out.valid & (tag_out.owner == OWN_D);
  assign i_data_out = i_rd_valid ? mem_DataOut : '0;
  assign d_data_out = d_rd_valid ? mem_DataOut : '0;

endmodule : mem_arbiter
